// File: rtl/miniled_pkg.sv
// rtl/miniled_pkg.sv - shared FSM state type and width helper for the MiniLED scan driver
// Contents:
//   state_t : scan driver FSM states
//   clog2   : bit width able to hold a given value
package miniled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY,
    ST_NEXT
  } state_t;

  // Number of bits needed to hold the value n itself (never less than 1).
  // Used for counters that must reach their limit, and for the write address
  // so that addresses at or above DEPTH stay expressible and can be rejected.
  function automatic int clog2(input int n);
    int v;
    int r;
    v = n;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/miniled_pingpong_ram.sv
// rtl/miniled_pingpong_ram.sv - two-bank frame buffer, write to back bank, read front bank
// Ports:
//   clk     : system clock
//   front   : bank currently displayed (0/1); writes go to the other bank
//   wr_en   : write strobe; addresses >= DEPTH are dropped
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address into the front bank
//   rd_data : read data, one cycle after rd_addr
module miniled_pingpong_ram #(
  parameter int DEPTH  = 384,
  parameter int GRAY_W = 16,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              front,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [GRAY_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [GRAY_W-1:0] rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [GRAY_W-1:0] bank0 [DEPTH];
  logic [GRAY_W-1:0] bank1 [DEPTH];

  logic wr_ok;
  assign wr_ok = wr_en && (32'(wr_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (wr_ok && front)  bank0[wr_addr[IW-1:0]] <= wr_data;
    if (wr_ok && !front) bank1[wr_addr[IW-1:0]] <= wr_data;
    rd_data <= front ? bank1[rd_addr[IW-1:0]] : bank0[rd_addr[IW-1:0]];
  end

endmodule

// File: rtl/miniled_scan_driver.sv
// rtl/miniled_scan_driver.sv - frame buffer, brightness scaler and scan/serial driver for MiniLED backlight
// Ports:
//   I_clk, I_rst        : clock, async active-high reset
//   I_en                : run frames continuously while high
//   I_wr_en/addr/data   : zone writes into the back bank
//   I_swap              : request bank swap at next frame start
//   I_bright            : global brightness, latched at frame start
//   O_LE/O_DCLK/O_SDI   : driver chip latch, shift clock, serial data
//   O_GCLK              : grayscale PWM clock
//   O_scan              : one-hot scan-line enable
//   O_busy/O_frame_done : frame in progress / end-of-frame pulse
module miniled_scan_driver
  import miniled_pkg::*;
#(
  parameter int NUM_SCAN    = 4,
  parameter int NUM_CHIPS   = 6,
  parameter int NUM_CH      = 16,
  parameter int GRAY_W      = 16,
  parameter int BRIGHT_W    = 8,
  parameter int DCLK_DIV    = 2,
  parameter int GCLK_PULSES = 1024,
  localparam int DEPTH      = NUM_SCAN * NUM_CHIPS * NUM_CH,
  localparam int AW         = clog2(DEPTH)
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic                I_en,
  input  logic                I_wr_en,
  input  logic [AW-1:0]       I_wr_addr,
  input  logic [GRAY_W-1:0]   I_wr_data,
  input  logic                I_swap,
  input  logic [BRIGHT_W-1:0] I_bright,
  output logic                O_LE,
  output logic                O_DCLK,
  output logic                O_SDI,
  output logic                O_GCLK,
  output logic [NUM_SCAN-1:0] O_scan,
  output logic                O_busy,
  output logic                O_frame_done
);

  localparam int WPL  = NUM_CHIPS * NUM_CH;
  localparam int SW   = clog2(NUM_SCAN - 1);
  localparam int WW   = clog2(WPL - 1);
  localparam int CMAX = (GRAY_W > GCLK_PULSES) ? GRAY_W : GCLK_PULSES;
  localparam int CW   = clog2(CMAX - 1);
  localparam int DW   = clog2(DCLK_DIV - 1);
  localparam int PW   = GRAY_W + BRIGHT_W + 1;

  state_t state, state_n;
  logic front, front_n, swap_pend, swap_pend_n;
  logic [BRIGHT_W-1:0] bright_r, bright_n;
  logic [SW-1:0] s, s_n;
  logic [WW-1:0] word_idx, word_n;
  logic [GRAY_W-1:0] sh, sh_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [1:0] phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic load_cnt, load_n, tick;
  logic le_d, dclk_d, sdi_d, gclk_d, busy_d, done_d;
  logic [NUM_SCAN-1:0] scan_d;
  logic [AW-1:0] rd_addr;
  logic [GRAY_W-1:0] rd_data, scaled;
  logic [PW-1:0] prod;

  // Line s occupies a contiguous block; words are read from the top of the
  // block down so the first word shifted ends up in the farthest chip.
  assign rd_addr = AW'(s) * AW'(WPL) + AW'(word_idx);
  assign prod    = PW'(rd_data) * (PW'(bright_r) + PW'(1));
  assign scaled  = GRAY_W'(prod >> BRIGHT_W);

  miniled_pingpong_ram #(.DEPTH(DEPTH), .GRAY_W(GRAY_W), .AW(AW)) u_ram (
    .clk(I_clk), .front(front), .wr_en(I_wr_en), .wr_addr(I_wr_addr),
    .wr_data(I_wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    front_n     = front;
    swap_pend_n = swap_pend | I_swap;
    bright_n    = bright_r;
    s_n         = s;
    word_n      = word_idx;
    sh_n        = sh;
    phase_n     = phase;
    cnt_n       = cnt;
    load_n      = load_cnt;
    done_d      = 1'b0;
    tick        = (div_cnt == DW'(DCLK_DIV - 1));
    div_n       = tick ? '0 : div_cnt + DW'(1);
    case (state)
      ST_IDLE: if (I_en) state_n = ST_START;
      ST_START: begin
        // A swap request arriving in this very cycle is honoured here too.
        front_n     = front ^ (swap_pend | I_swap);
        swap_pend_n = 1'b0;
        bright_n    = I_bright;
        s_n         = '0;
        word_n      = WW'(WPL - 1);
        state_n     = ST_LOAD;
      end
      ST_LOAD: begin
        load_n = 1'b1;
        if (load_cnt) begin
          sh_n    = scaled;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: if (tick) begin
        if (phase == 2'd0) phase_n = 2'd1;
        else begin
          phase_n = 2'd0;
          sh_n    = sh << 1;
          cnt_n   = cnt + CW'(1);
          if (cnt == CW'(GRAY_W - 1)) begin
            if (word_idx == '0) state_n = ST_LATCH;
            else begin
              word_n  = word_idx - WW'(1);
              state_n = ST_LOAD;
            end
          end
        end
      end
      // phases 0,1: LE high; phase 2: LE low, DCLK low guard before display
      ST_LATCH: if (tick) begin
        phase_n = phase + 2'd1;
        if (phase == 2'd2) state_n = ST_DISPLAY;
      end
      ST_DISPLAY: if (tick) begin
        if (phase == 2'd0) phase_n = 2'd1;
        else begin
          phase_n = 2'd0;
          cnt_n   = cnt + CW'(1);
          if (cnt == CW'(GCLK_PULSES - 1)) state_n = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (s == SW'(NUM_SCAN - 1)) begin
          done_d  = 1'b1;
          state_n = I_en ? ST_START : ST_IDLE;
        end else begin
          s_n     = s + SW'(1);
          word_n  = WW'(WPL - 1);
          state_n = ST_LOAD;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n != state) begin
      div_n   = '0;
      phase_n = 2'd0;
      cnt_n   = '0;
      load_n  = 1'b0;
    end
    le_d   = (state == ST_LATCH) && (phase != 2'd2);
    dclk_d = (state == ST_SHIFT) && (phase == 2'd1);
    sdi_d  = (state == ST_SHIFT) && sh[GRAY_W-1];
    gclk_d = (state == ST_DISPLAY) && (phase == 2'd1);
    scan_d = (state == ST_DISPLAY) ? (NUM_SCAN'(1) << s) : '0;
    // Taken from the next state so busy rises with START and falls together
    // with the frame_done pulse.
    busy_d = (state_n != ST_IDLE);
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      front <= 1'b0;      swap_pend <= 1'b0;  bright_r <= '0;
      s <= '0;            word_idx <= '0;     sh <= '0;
      div_cnt <= '0;      phase <= 2'd0;      cnt <= '0;
      load_cnt <= 1'b0;
      O_LE <= 1'b0;       O_DCLK <= 1'b0;     O_SDI <= 1'b0;
      O_GCLK <= 1'b0;     O_scan <= '0;       O_busy <= 1'b0;
      O_frame_done <= 1'b0;
    end else begin
      front <= front_n;   swap_pend <= swap_pend_n; bright_r <= bright_n;
      s <= s_n;           word_idx <= word_n; sh <= sh_n;
      div_cnt <= div_n;   phase <= phase_n;   cnt <= cnt_n;
      load_cnt <= load_n;
      O_LE <= le_d;       O_DCLK <= dclk_d;   O_SDI <= sdi_d;
      O_GCLK <= gclk_d;   O_scan <= scan_d;   O_busy <= busy_d;
      O_frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_miniled_scan_driver.sv
// tb/tb_miniled_scan_driver.sv - directed self-checking bench for miniled_scan_driver (2 scans, 2 words/line, 4-bit gray)
module tb_miniled_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       swap = 1'b0;
  logic [7:0] bright = '0;
  logic       le, dclk, sdi, gclk, busy, frame_done;
  logic [1:0] scan;

  int    checks = 0;
  int    failures = 0;
  string cap;

  always #5 clk = ~clk;

  miniled_scan_driver #(
    .NUM_SCAN(2), .NUM_CHIPS(1), .NUM_CH(2), .GRAY_W(4), .BRIGHT_W(8),
    .DCLK_DIV(1), .GCLK_PULSES(4)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_en(en), .I_wr_en(wr_en), .I_wr_addr(wr_addr),
    .I_wr_data(wr_data), .I_swap(swap), .I_bright(bright), .O_LE(le),
    .O_DCLK(dclk), .O_SDI(sdi), .O_GCLK(gclk), .O_scan(scan), .O_busy(busy),
    .O_frame_done(frame_done)
  );

  task automatic write_word(input logic [2:0] a, input logic [3:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap;
    @(posedge clk); #1 swap = 1'b1;
    @(posedge clk); #1 swap = 1'b0;
  endtask

  task automatic start_frame;
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk);
  endtask

  // Records one frame as text: wX shifted word, Ln LE run length, Sn scan
  // value at display start, Gn GCLK rises in that display, F frame_done.
  task automatic capture_frame(input int budget);
    logic pd, pl, pg;
    logic [1:0] ps;
    logic [3:0] w;
    int nb, lr, gr, bad;
    cap = ""; pd = 0; pl = 0; pg = 0; ps = 0; w = 0; nb = 0; lr = 0; gr = 0; bad = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (dclk && !pd) begin
        w = {w[2:0], sdi};
        nb++;
        if (nb == 4) begin cap = {cap, $sformatf(" w%h", w)}; nb = 0; end
      end
      if (le) lr++;
      else if (pl) begin cap = {cap, $sformatf(" L%0d", lr)}; lr = 0; end
      if (scan != 0 && ps == 0) begin cap = {cap, $sformatf(" S%0d", scan)}; gr = 0; end
      if (gclk && !pg) begin if (scan == 0) bad++; gr++; end
      if (scan == 0 && ps != 0) cap = {cap, $sformatf(" G%0d", gr)};
      if ((int'(le) + int'(dclk) + int'(gclk)) > 1 || scan == 2'b11) bad++;
      pd = dclk; pl = le; pg = gclk; ps = scan;
      if (frame_done) begin
        cap = {cap, " F"};
        if (bad != 0) cap = {cap, $sformatf(" B%0d", bad)};
        return;
      end
      if (!busy) bad++;
    end
    cap = {cap, " TIMEOUT"};
  endtask

  task automatic stop_run;
    @(posedge clk); #1 en = 1'b0;
    for (int n = 0; n < 500 && busy; n++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({le, dclk, sdi, gclk, scan, busy, frame_done} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0", {le, dclk, sdi, gclk, scan, busy, frame_done});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({le, dclk, sdi, gclk, scan, busy, frame_done} !== 8'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b required=0", {le, dclk, sdi, gclk, scan, busy, frame_done});
    end
  endtask

  task automatic test_serial_order;
    write_word(3'd0, 4'h1); write_word(3'd1, 4'h8);
    write_word(3'd2, 4'h3); write_word(3'd3, 4'hF);
    pulse_swap;
    bright = 8'hFF;
    start_frame;
    capture_frame(1000);
    checks++;
    if (cap != " w8 w1 L2 S1 G4 wf w3 L2 S2 G4 F") begin
      failures++;
      $display("FAIL serial_order got=%s required= w8 w1 L2 S1 G4 wf w3 L2 S2 G4 F", cap);
    end
    stop_run;
  endtask

  task automatic test_brightness;
    for (int a = 0; a < 4; a++) write_word(3'(a), 4'hF);
    pulse_swap;
    bright = 8'h7F;
    start_frame;
    capture_frame(1000);
    checks++;
    if (cap != " w7 w7 L2 S1 G4 w7 w7 L2 S2 G4 F") begin
      failures++;
      $display("FAIL bright_7f got=%s required= w7 w7 L2 S1 G4 w7 w7 L2 S2 G4 F", cap);
    end
    stop_run;
    bright = 8'h00;
    start_frame;
    fork
      capture_frame(1000);
      begin repeat (8) @(posedge clk); #1 bright = 8'hFF; end
    join
    checks++;
    if (cap != " w0 w0 L2 S1 G4 w0 w0 L2 S2 G4 F") begin
      failures++;
      $display("FAIL bright_00 got=%s required= w0 w0 L2 S1 G4 w0 w0 L2 S2 G4 F", cap);
    end
    capture_frame(1000);
    checks++;
    if (cap != " wf wf L2 S1 G4 wf wf L2 S2 G4 F") begin
      failures++;
      $display("FAIL bright_next_start got=%s required= wf wf L2 S1 G4 wf wf L2 S2 G4 F", cap);
    end
    stop_run;
  endtask

  task automatic test_deferred_swap;
    bright = 8'hFF;
    start_frame;
    fork
      capture_frame(1000);
      begin
        repeat (10) @(posedge clk);
        write_word(3'd0, 4'h2); write_word(3'd1, 4'h4);
        write_word(3'd2, 4'h6); write_word(3'd3, 4'h9);
        pulse_swap;
      end
    join
    checks++;
    if (cap != " wf wf L2 S1 G4 wf wf L2 S2 G4 F") begin
      failures++;
      $display("FAIL deferred_old got=%s required= wf wf L2 S1 G4 wf wf L2 S2 G4 F", cap);
    end
    capture_frame(1000);
    checks++;
    if (cap != " w4 w2 L2 S1 G4 w9 w6 L2 S2 G4 F") begin
      failures++;
      $display("FAIL deferred_new got=%s required= w4 w2 L2 S1 G4 w9 w6 L2 S2 G4 F", cap);
    end
    stop_run;
  endtask

  task automatic test_stop;
    int extra_done, active;
    start_frame;
    fork
      capture_frame(1000);
      begin repeat (5) @(posedge clk); #1 en = 1'b0; end
    join
    checks++;
    if (cap != " w4 w2 L2 S1 G4 w9 w6 L2 S2 G4 F") begin
      failures++;
      $display("FAIL stop_frame got=%s required= w4 w2 L2 S1 G4 w9 w6 L2 S2 G4 F", cap);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_busy_at_done got=%b required=0", busy);
    end
    extra_done = 0; active = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (frame_done) extra_done++;
      if ({le, dclk, sdi, gclk, scan, busy} != 7'b0) active++;
    end
    checks++;
    if (extra_done !== 0) begin
      failures++;
      $display("FAIL stop_extra_done got=%0d required=0", extra_done);
    end
    checks++;
    if (active !== 0) begin
      failures++;
      $display("FAIL stop_outputs_idle got=%0d active cycles required=0", active);
    end
  endtask

  task automatic test_out_of_range;
    write_word(3'd4, 4'h5); write_word(3'd5, 4'hA);
    write_word(3'd6, 4'h3); write_word(3'd7, 4'hC);
    bright = 8'hFF;
    start_frame;
    fork
      capture_frame(1000);
      begin #1 swap = 1'b1; @(posedge clk); #1 swap = 1'b0; end
    join
    checks++;
    if (cap != " wf wf L2 S1 G4 wf wf L2 S2 G4 F") begin
      failures++;
      $display("FAIL out_of_range_swap_at_start got=%s required= wf wf L2 S1 G4 wf wf L2 S2 G4 F", cap);
    end
    stop_run;
  endtask

  task automatic test_reset_mid_shift;
    int active;
    start_frame;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dclk) break;
    end
    checks++;
    if (dclk !== 1'b1) begin
      failures++;
      $display("FAIL mid_shift_reach got=%b required=1", dclk);
    end
    #2 rst = 1'b1; en = 1'b0;
    #1;
    checks++;
    if ({le, dclk, sdi, gclk, scan, busy, frame_done} !== 8'b0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b required=0", {le, dclk, sdi, gclk, scan, busy, frame_done});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    active = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if ({le, dclk, sdi, gclk, scan, busy, frame_done} != 8'b0) active++;
    end
    checks++;
    if (active !== 0) begin
      failures++;
      $display("FAIL idle_after_mid_reset got=%0d active cycles required=0", active);
    end
  endtask

  initial begin
    test_reset;
    test_serial_order;
    test_brightness;
    test_deferred_swap;
    test_stop;
    test_out_of_range;
    test_reset_mid_shift;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
